// File: rtl/farm_pkg.sv
// Shared definitions for the farm sensor hub.
//   SAMPLE_W      : width of a sensor sample / channel average
//   DEF_HI/DEF_LO : alert thresholds restored at reset
//   pump_state_e  : pump controller states, encoding visible on pump_state
package farm_pkg;

  localparam int SAMPLE_W = 8;

  localparam logic [SAMPLE_W-1:0] DEF_HI = 8'd128;
  localparam logic [SAMPLE_W-1:0] DEF_LO = 8'd112;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    COOL = 2'd2
  } pump_state_e;

endpackage

// File: rtl/farm_ch_avg.sv
// Moving average over the last 2^DEPTH_LOG2 samples of one sensor channel.
//   clk, rst_n : clock, synchronous active-low reset
//   ena        : global enable, all state holds when low
//   s_we       : accept s_data this cycle
//   s_data     : sample value
//   avg        : registered average, valid the cycle after a sample
//   warm       : history has been completely filled at least once
module farm_ch_avg
  import farm_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                s_we,
  input  logic [SAMPLE_W-1:0] s_data,
  output logic [SAMPLE_W-1:0] avg,
  output logic                warm
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SUM_W = SAMPLE_W + DEPTH_LOG2;

  logic [SAMPLE_W-1:0]   hist [DEPTH];
  logic [DEPTH_LOG2-1:0] ptr;
  logic [SUM_W-1:0]      sum;
  logic [SUM_W-1:0]      sum_nx;

  // The slot under the write pointer always holds the oldest sample
  // (zero until the history has wrapped once).
  assign sum_nx = sum - SUM_W'(hist[ptr]) + SUM_W'(s_data);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      ptr  <= '0;
      sum  <= '0;
      avg  <= '0;
      warm <= 1'b0;
    end else if (ena && s_we) begin
      hist[ptr] <= s_data;
      ptr       <= ptr + 1'b1;
      sum       <= sum_nx;
      avg       <= sum_nx[SUM_W-1:DEPTH_LOG2];
      if (&ptr) warm <= 1'b1;
    end
  end

endmodule

// File: rtl/farm_sensor_hub.sv
// Multi-channel soil sensor hub: per-channel moving averages with
// hysteretic alerts, plus an irrigation pump controller driven by channel 0.
//   clk, rst_n          : clock, synchronous active-low reset
//   ena                 : global enable, all state holds when low
//   s_valid/s_ch/s_data : sample input
//   cfg_we/cfg_ch/cfg_hi/cfg_lo : per-channel alert threshold write
//   auto_mode, dry_thr, wet_thr : irrigation control
//   rd_ch/rd_avg        : average readback
//   alert, alert_cnt    : per-channel alert flags and their popcount
//   warm                : per-channel history-full flags
//   pump_on, valve_open : pump/valve drive (identical)
//   pump_state          : pump FSM state
//
// Pump FSM
//   state | meaning
//   IDLE  | pump off, waiting for channel 0 to read dry
//   RUN   | pump on, timer counts down the maximum run length
//   COOL  | pump off, timer counts down the minimum rest; dryness ignored
module farm_sensor_hub
  import farm_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DEPTH_LOG2 = 2,
  parameter int PUMP_TICKS = 1000,
  parameter int COOL_TICKS = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      s_valid,
  input  logic [$clog2(NUM_CH)-1:0] s_ch,
  input  logic [7:0]                s_data,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [7:0]                cfg_hi,
  input  logic [7:0]                cfg_lo,
  input  logic                      auto_mode,
  input  logic [7:0]                dry_thr,
  input  logic [7:0]                wet_thr,
  input  logic [$clog2(NUM_CH)-1:0] rd_ch,
  output logic [7:0]                rd_avg,
  output logic [NUM_CH-1:0]         alert,
  output logic [$clog2(NUM_CH):0]   alert_cnt,
  output logic [NUM_CH-1:0]         warm,
  output logic                      pump_on,
  output logic                      valve_open,
  output logic [1:0]                pump_state
);

  localparam int CH_W     = $clog2(NUM_CH);
  localparam int CNT_W    = CH_W + 1;
  localparam int CH_SLOTS = 1 << CH_W;
  localparam int TMR_MAX  = (PUMP_TICKS > COOL_TICKS) ? PUMP_TICKS : COOL_TICKS;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);

  // Padded to a power of two so any rd_ch value indexes a real entry.
  logic [SAMPLE_W-1:0] avg_slot [CH_SLOTS];

  for (genvar i = 0; i < CH_SLOTS; i++) begin : g_ch
    if (i < NUM_CH) begin : g_real
      logic                s_hit;
      logic                c_hit;
      logic [SAMPLE_W-1:0] thr_hi;
      logic [SAMPLE_W-1:0] thr_lo;
      logic                alert_r;

      assign s_hit = s_valid && (s_ch == CH_W'(i));
      assign c_hit = cfg_we && (cfg_ch == CH_W'(i));

      farm_ch_avg #(.DEPTH_LOG2(DEPTH_LOG2)) u_avg (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .s_we   (s_hit),
        .s_data (s_data),
        .avg    (avg_slot[i]),
        .warm   (warm[i])
      );

      // Alert compares the registered average against the registered
      // thresholds, so a same-cycle threshold write only counts next cycle.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          thr_hi  <= DEF_HI;
          thr_lo  <= DEF_LO;
          alert_r <= 1'b0;
        end else if (ena) begin
          if (c_hit) begin
            thr_hi <= cfg_hi;
            thr_lo <= cfg_lo;
          end
          if (!warm[i])                  alert_r <= 1'b0;
          else if (avg_slot[i] > thr_hi) alert_r <= 1'b1;
          else if (avg_slot[i] < thr_lo) alert_r <= 1'b0;
        end
      end

      assign alert[i] = alert_r;
    end else begin : g_pad
      assign avg_slot[i] = '0;
    end
  end

  assign rd_avg = avg_slot[rd_ch];

  always_comb begin
    alert_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) alert_cnt = alert_cnt + CNT_W'(alert[i]);
  end

  pump_state_e       state, state_nx;
  logic [TMR_W-1:0]  timer, timer_nx;
  logic [SAMPLE_W-1:0] avg0;

  assign avg0 = avg_slot[0];

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    case (state)
      IDLE: begin
        if (auto_mode && warm[0] && (avg0 < dry_thr)) begin
          state_nx = RUN;
          timer_nx = TMR_W'(PUMP_TICKS);
        end
      end
      RUN: begin
        if ((timer == TMR_W'(1)) || (avg0 > wet_thr) || !auto_mode) begin
          state_nx = COOL;
          timer_nx = TMR_W'(COOL_TICKS);
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      COOL: begin
        timer_nx = timer - 1'b1;
        if (timer == TMR_W'(1)) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        timer_nx = '0;
      end
    endcase
  end

  // pump_on is registered from the next state so it tracks RUN exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      pump_on <= 1'b0;
    end else if (ena) begin
      state   <= state_nx;
      timer   <= timer_nx;
      pump_on <= (state_nx == RUN);
    end
  end

  assign valve_open = pump_on;
  assign pump_state = state;

endmodule

// File: tb/tb_farm_sensor_hub.sv
module tb_farm_sensor_hub;

  localparam int NUM_CH = 4;

  logic       clk = 1'b0;
  logic       rst_n, ena, s_valid, cfg_we, auto_mode;
  logic [1:0] s_ch, cfg_ch, rd_ch;
  logic [7:0] s_data, cfg_hi, cfg_lo, dry_thr, wet_thr, rd_avg;
  logic [3:0] alert, warm;
  logic [2:0] alert_cnt;
  logic       pump_on, valve_open;
  logic [1:0] pump_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  farm_sensor_hub #(
    .NUM_CH(NUM_CH), .DEPTH_LOG2(2), .PUMP_TICKS(10), .COOL_TICKS(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .s_valid(s_valid), .s_ch(s_ch), .s_data(s_data),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_hi(cfg_hi), .cfg_lo(cfg_lo),
    .auto_mode(auto_mode), .dry_thr(dry_thr), .wet_thr(wet_thr),
    .rd_ch(rd_ch), .rd_avg(rd_avg), .alert(alert), .alert_cnt(alert_cnt),
    .warm(warm), .pump_on(pump_on), .valve_open(valve_open),
    .pump_state(pump_state)
  );

  typedef struct {
    logic       en;
    logic       sv;
    logic [1:0] sc;
    logic [7:0] sd;
    logic       cw;
    logic [1:0] cc;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [1:0] rc;
    logic [7:0] e_avg;
    logic [3:0] e_warm;
    logic [3:0] e_alert;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t vt [26];

  function automatic vec_t mk(logic en, logic sv, logic [1:0] sc, logic [7:0] sd,
                              logic cw, logic [1:0] cc, logic [7:0] hi, logic [7:0] lo,
                              logic [1:0] rc, logic [7:0] ea, logic [3:0] ew,
                              logic [3:0] eal, logic [2:0] ec);
    vec_t v;
    v.en = en; v.sv = sv; v.sc = sc; v.sd = sd; v.cw = cw; v.cc = cc;
    v.hi = hi; v.lo = lo; v.rc = rc; v.e_avg = ea; v.e_warm = ew;
    v.e_alert = eal; v.e_cnt = ec;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [1:0] ch, logic [7:0] d);
    s_valid = 1'b1; s_ch = ch; s_data = d;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_state(logic [1:0] st, string name);
    int n;
    n = 0;
    while (pump_state != st && n < 60) begin
      tick();
      n++;
    end
    check(name, (n < 60) ? 1 : 0, 1);
  endtask

  initial begin
    int n;
    int k;

    // en sv ch data  cw cc hi lo  rd  avg warm alert cnt
    vt[0]  = mk(1,0,0,  0, 0,0,  0,  0, 0,   0,4'b0000,4'b0000,0);
    vt[1]  = mk(1,1,1, 40, 0,0,  0,  0, 1,  10,4'b0000,4'b0000,0);
    vt[2]  = mk(1,1,1, 80, 0,0,  0,  0, 1,  30,4'b0000,4'b0000,0);
    vt[3]  = mk(1,1,1,120, 0,0,  0,  0, 1,  60,4'b0000,4'b0000,0);
    vt[4]  = mk(1,1,1,160, 0,0,  0,  0, 1, 100,4'b0010,4'b0000,0);
    vt[5]  = mk(1,1,1,200, 0,0,  0,  0, 1, 140,4'b0010,4'b0000,0);
    vt[6]  = mk(1,0,0,  0, 0,0,  0,  0, 1, 140,4'b0010,4'b0010,1);
    vt[7]  = mk(1,1,1,200, 1,1,255,200, 1, 170,4'b0010,4'b0010,1);
    vt[8]  = mk(1,0,0,  0, 0,0,  0,  0, 1, 170,4'b0010,4'b0000,0);
    vt[9]  = mk(1,0,0,  0, 1,2,150,100, 2,   0,4'b0010,4'b0000,0);
    vt[10] = mk(1,1,2,160, 0,0,  0,  0, 2,  40,4'b0010,4'b0000,0);
    vt[11] = mk(1,1,2,160, 0,0,  0,  0, 2,  80,4'b0010,4'b0000,0);
    vt[12] = mk(1,1,2,160, 0,0,  0,  0, 2, 120,4'b0010,4'b0000,0);
    vt[13] = mk(1,1,2,160, 0,0,  0,  0, 2, 160,4'b0110,4'b0000,0);
    vt[14] = mk(1,0,0,  0, 0,0,  0,  0, 2, 160,4'b0110,4'b0100,1);
    vt[15] = mk(1,1,2,120, 0,0,  0,  0, 2, 150,4'b0110,4'b0100,1);
    vt[16] = mk(1,1,2,120, 0,0,  0,  0, 2, 140,4'b0110,4'b0100,1);
    vt[17] = mk(1,1,2,120, 0,0,  0,  0, 2, 130,4'b0110,4'b0100,1);
    vt[18] = mk(1,1,2,120, 0,0,  0,  0, 2, 120,4'b0110,4'b0100,1);
    vt[19] = mk(1,0,0,  0, 0,0,  0,  0, 2, 120,4'b0110,4'b0100,1);
    vt[20] = mk(1,1,2, 90, 0,0,  0,  0, 2, 112,4'b0110,4'b0100,1);
    vt[21] = mk(1,1,2, 90, 0,0,  0,  0, 2, 105,4'b0110,4'b0100,1);
    vt[22] = mk(1,1,2, 90, 0,0,  0,  0, 2,  97,4'b0110,4'b0100,1);
    vt[23] = mk(1,1,2, 90, 0,0,  0,  0, 2,  90,4'b0110,4'b0000,0);
    vt[24] = mk(0,1,2,255, 1,2,  0,255, 2,  90,4'b0110,4'b0000,0);
    vt[25] = mk(1,0,0,  0, 0,0,  0,  0, 3,   0,4'b0110,4'b0000,0);

    rst_n = 1'b0; ena = 1'b1; s_valid = 1'b0; s_ch = '0; s_data = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_hi = '0; cfg_lo = '0;
    auto_mode = 1'b0; dry_thr = 8'd80; wet_thr = 8'd250; rd_ch = '0;
    tick(); tick();
    rst_n = 1'b1;
    check("reset_state", pump_state, 0);
    check("reset_pump", pump_on, 0);

    for (int i = 0; i < 26; i++) begin
      ena = vt[i].en; s_valid = vt[i].sv; s_ch = vt[i].sc; s_data = vt[i].sd;
      cfg_we = vt[i].cw; cfg_ch = vt[i].cc; cfg_hi = vt[i].hi; cfg_lo = vt[i].lo;
      rd_ch = vt[i].rc;
      tick();
      ena = 1'b1; s_valid = 1'b0; cfg_we = 1'b0;
      check($sformatf("v%0d_avg", i), rd_avg, vt[i].e_avg);
      check($sformatf("v%0d_warm", i), warm, vt[i].e_warm);
      check($sformatf("v%0d_alert", i), alert, vt[i].e_alert);
      check($sformatf("v%0d_cnt", i), alert_cnt, vt[i].e_cnt);
    end
    check("table_pump_idle", pump_state, 0);

    // Timeout run, cool-down, re-entry
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    auto_mode = 1'b1; dry_thr = 8'd80; wet_thr = 8'd250; rd_ch = 2'd0;
    for (int i = 0; i < 4; i++) send(2'd0, 8'd50);
    check("ch0_avg50", rd_avg, 50);
    check("pre_run_idle", pump_state, 0);
    n = 0;
    tick();
    while (pump_on && n < 50) begin
      check("valve_eq_pump_run", valve_open, pump_on);
      n++;
      tick();
    end
    check("run_len", n, 10);
    n = 0;
    while (pump_state == 2'd2 && n < 50) begin
      check("cool_pump_off", pump_on, 0);
      n++;
      tick();
    end
    check("cool_len", n, 5);
    check("after_cool_idle", pump_state, 0);
    tick();
    check("reenter_run", pump_state, 1);
    check("reenter_pump", pump_on, 1);

    // ena low for 3 cycles mid-run stretches the run by 3
    n = 1;
    k = 0;
    while (k < 60) begin
      ena = !(k >= 2 && k < 5);
      tick();
      k++;
      if (!pump_on) break;
      n++;
    end
    ena = 1'b1;
    check("run_len_with_freeze", n, 13);

    // Early stop on wet reading
    wait_state(2'd1, "wait_run_early");
    wet_thr = 8'd180;
    send(2'd0, 8'd200);
    send(2'd0, 8'd200);
    send(2'd0, 8'd200);
    check("avg_162", rd_avg, 162);
    check("still_run_162", pump_state, 1);
    send(2'd0, 8'd200);
    check("avg_200", rd_avg, 200);
    check("run_at_wet_avg", pump_state, 1);
    tick();
    check("early_cool", pump_state, 2);
    check("early_pump_off", pump_on, 0);

    // Reset mid-run
    wet_thr = 8'd250;
    for (int i = 0; i < 4; i++) send(2'd0, 8'd50);
    wait_state(2'd1, "wait_run_rst");
    check("pre_rst_pump", pump_on, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_pump", pump_on, 0);
    check("rst_valve", valve_open, 0);
    check("rst_state", pump_state, 0);
    check("rst_warm", warm, 0);
    check("rst_alert", alert, 0);
    check("rst_cnt", alert_cnt, 0);
    check("rst_avg", rd_avg, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/farm_sensor_hub.md
FARM_SENSOR_HUB -- requirements
Module: farm_sensor_hub

Interface
REQ-001 Parameter NUM_CH, default 4: number of sensor channels, 2..8.
REQ-002 Parameter DEPTH_LOG2, default 2: log2 of history depth per channel, 1..4.
REQ-003 Parameter PUMP_TICKS, default 1000: maximum pump-on duration in cycles.
REQ-004 Parameter COOL_TICKS, default 256: minimum pump-off time after a run, in cycles.
REQ-005 Ports SHALL be:
  clk  in  1  clock.
  rst_n  in  1  reset; synchronous, active-low.
  ena  in  1  global enable; when low, all state holds.
  s_valid  in  1  sample strobe.
  s_ch  in  clog2(NUM_CH)  sample channel index.
  s_data  in  8  sample value.
  cfg_we  in  1  threshold write strobe.
  cfg_ch  in  clog2(NUM_CH)  channel index for the threshold write.
  cfg_hi  in  8  alert-set threshold.
  cfg_lo  in  8  alert-clear threshold.
  auto_mode  in  1  enables automatic irrigation.
  dry_thr  in  8  channel-0 average below which a pump run starts.
  wet_thr  in  8  channel-0 average above which a pump run stops early.
  rd_ch  in  clog2(NUM_CH)  average readback select.
  rd_avg  out  8  average of channel rd_ch; combinational from registers.
  alert  out  NUM_CH  per-channel alert flags.
  alert_cnt  out  clog2(NUM_CH)+1  popcount of alert.
  warm  out  NUM_CH  per-channel flag: history is full.
  pump_on  out  1  pump drive.
  valve_open  out  1  valve drive; always equal to pump_on.
  pump_state  out  2  FSM state encoding.

Function
REQ-006 Each channel SHALL keep a circular history of 2^DEPTH_LOG2 samples, a write pointer, and a running sum of width 8+DEPTH_LOG2.
REQ-007 On a cycle with ena and s_valid high, channel s_ch SHALL update as follows: sum <= sum - oldest + s_data; the oldest slot <= s_data; the pointer increments and wraps modulo depth.
REQ-008 On the same edge, the channel average SHALL be loaded from the updated sum shifted right by DEPTH_LOG2, so the average is valid 1 cycle after the sample.
REQ-009 The warm flag for a channel SHALL set once that channel has accepted 2^DEPTH_LOG2 samples, and then stay set until reset.
REQ-010 Alert flags SHALL update 1 cycle after the average, with hysteresis: set when warm and avg > hi; clear when avg < lo; otherwise hold.
REQ-011 A channel that is not warm SHALL have its alert flag held at 0.
REQ-012 Threshold writes (cfg_we) SHALL take effect on the next edge; reset values are hi=128 and lo=112.
REQ-013 If a threshold write and a sample hit the same channel in the same cycle, both SHALL apply; the alert comparison uses the old thresholds in that cycle.
REQ-014 The pump FSM SHALL have three states: IDLE=0, RUN=1, COOL=2. Its timer is clog2(max(PUMP_TICKS, COOL_TICKS)+1) bits wide.
REQ-015 IDLE -> RUN SHALL occur when auto_mode is high, warm[0] is set, and avg0 < dry_thr. On entry, the timer loads PUMP_TICKS.
REQ-016 In RUN, the timer SHALL decrement every enabled cycle.
REQ-017 RUN -> COOL SHALL occur when the timer reaches 1, or when avg0 > wet_thr, or when auto_mode drops. On entry, the timer loads COOL_TICKS.
REQ-018 In COOL, the timer SHALL decrement; COOL -> IDLE occurs when the timer reaches 1. Dry conditions SHALL be ignored while in COOL.
REQ-019 pump_on and valve_open SHALL be registered, and SHALL be high exactly while the state is RUN, with no extra cycle of delay.
REQ-020 Samples with s_ch >= NUM_CH SHALL be ignored; cfg writes with cfg_ch >= NUM_CH SHALL be ignored.
REQ-021 When ena is low, no register SHALL change, including the timers.

Reset
REQ-022 On reset, the following SHALL clear to 0: histories, sums, averages, pointers, warm, alert, and pump_state (IDLE).
REQ-023 On reset, thresholds SHALL return to 128/112 and the timer SHALL clear.
REQ-024 Reset asserted during RUN SHALL drop pump_on and valve_open on the same edge.

Structure
REQ-025 A shared package farm_pkg SHALL hold: the pump-state enum (IDLE, RUN, COOL), the default thresholds 128/112, and the 8-bit sample width constant.
REQ-026 Per-channel history, sum and average SHALL live in a sub-module farm_ch_avg, instantiated NUM_CH times through a generate loop.
REQ-027 The pump FSM and alert popcount SHALL remain in the top level.

Verification
REQ-028 Warm-up: with DEPTH_LOG2=2, send samples 40, 80, 120, 160 to ch1. Required: warm[1] sets after the 4th sample; rd_avg (rd_ch=1) reads 100 one cycle later.
REQ-029 Wrap-around: after REQ-028, send a 5th sample of 200 to ch1. Required: the 40 is replaced and rd_avg reads 140.
REQ-030 Hysteresis: set ch2 thresholds hi=150, lo=100 and fill ch2 with 160. Required: alert[2]=1 and alert_cnt=1. Then fill with 120: alert stays 1. Then fill with 90: alert clears.
REQ-031 Timeout run: with PUMP_TICKS=10, COOL_TICKS=5, auto_mode=1, dry_thr=80, fill ch0 with 50. Required: pump_on goes high for exactly 10 cycles, then stays low for 5 cycles in COOL, then re-enters RUN.
REQ-032 Early stop: during RUN, fill ch0 with 200 with wet_thr=180. Required: the FSM enters COOL one cycle after the avg exceeds 180.
REQ-033 Disturbances: pulse ena low for 3 cycles mid-RUN. Required: the timer freezes for those cycles. Assert rst_n low mid-RUN. Required: pump_on=0 and all outputs at reset values on the next edge.
